// File: rtl/harvos_dma_copy_master.sv
// Word-granular memory-to-memory DMA initiator on a req/done bus.
// Software programs SRC/DST/LEN and starts a copy. The block then issues
// alternating read/write beats with a one-cycle request gap between beats,
// and reports done/fault/alignment errors in STATUS and on a level IRQ.
module harvos_dma_copy_master #(
    parameter int unsigned LEN_W       = 16,
    parameter bit          IRQ_DEFAULT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_en,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_done,
    input  logic        m_fault,
    output logic        irq
);

    localparam logic [3:0] REG_SRC    = 4'd0;
    localparam logic [3:0] REG_DST    = 4'd1;
    localparam logic [3:0] REG_LEN    = 4'd2;
    localparam logic [3:0] REG_CTRL   = 4'd3;
    localparam logic [3:0] REG_STATUS = 4'd4;
    localparam logic [3:0] REG_FADDR  = 4'd5;
    localparam logic [3:0] REG_REMAIN = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [31:0]        src_ptr_q, src_ptr_d;
    logic [31:0]        dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]   remain_q, remain_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        fault_addr_q, fault_addr_d;
    logic               gap_q, gap_d;
    logic               abort_pend_q, abort_pend_d;
    logic               irq_en_q, irq_en_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;
    logic               align_q, align_d;

    logic               busy;
    logic               wr_cfg;
    logic               start_req;
    logic               abort_req;
    logic               misaligned;

    assign busy       = (state_q != ST_IDLE);
    assign wr_cfg     = cfg_en & cfg_we;
    assign start_req  = wr_cfg & (cfg_addr == REG_CTRL) & cfg_wdata[0];
    assign abort_req  = wr_cfg & (cfg_addr == REG_CTRL) & cfg_wdata[1];
    assign misaligned = (|src_q[1:0]) | (|dst_q[1:0]);

    // Bus outputs: request is suppressed in IDLE and during the re-arbitration gap
    assign m_req   = busy & ~gap_q;
    assign m_we    = m_req & (state_q == ST_WR);
    assign m_be    = {4{m_we}};
    assign m_addr  = !m_req ? '0 : (m_we ? dst_ptr_q : src_ptr_q);
    assign m_wdata = m_we ? data_q : '0;
    assign irq     = irq_en_q & (done_q | fault_q | align_q);

    // Config read mux, combinational from cfg_addr
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_SRC:    cfg_rdata = src_q;
            REG_DST:    cfg_rdata = dst_q;
            REG_LEN:    cfg_rdata = 32'(len_q);
            REG_CTRL:   cfg_rdata = {29'b0, irq_en_q, 2'b0};
            REG_STATUS: cfg_rdata = {28'b0, align_q, fault_q, done_q, busy};
            REG_FADDR:  cfg_rdata = fault_addr_q;
            REG_REMAIN: cfg_rdata = 32'(remain_q);
            default:    cfg_rdata = '0;
        endcase
    end

    // Next-state logic: config writes, W1C status, then FSM (FSM sets win over clears)
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        remain_d     = remain_q;
        data_d       = data_q;
        fault_addr_d = fault_addr_q;
        gap_d        = 1'b0;
        abort_pend_d = abort_pend_q;
        irq_en_d     = irq_en_q;
        done_d       = done_q;
        fault_d      = fault_q;
        align_d      = align_q;

        if (wr_cfg && !busy) begin
            if (cfg_addr == REG_SRC) src_d = cfg_wdata;
            if (cfg_addr == REG_DST) dst_d = cfg_wdata;
            if (cfg_addr == REG_LEN) len_d = cfg_wdata[LEN_W-1:0];
        end
        if (wr_cfg && (cfg_addr == REG_CTRL)) irq_en_d = cfg_wdata[2];
        if (wr_cfg && (cfg_addr == REG_STATUS)) begin
            if (cfg_wdata[1]) done_d  = 1'b0;
            if (cfg_wdata[2]) fault_d = 1'b0;
            if (cfg_wdata[3]) align_d = 1'b0;
        end
        if (abort_req && busy) abort_pend_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (start_req) begin
                    // Every accepted start clears the sticky flags before setting its own
                    done_d  = 1'b0;
                    fault_d = 1'b0;
                    align_d = 1'b0;
                    if (misaligned) begin
                        align_d = 1'b1;
                    end else if (len_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        src_ptr_d = src_q;
                        dst_ptr_d = dst_q;
                        remain_d  = len_q;
                        state_d   = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (!gap_q) begin
                    if (m_fault) begin
                        fault_d      = 1'b1;
                        fault_addr_d = src_ptr_q;
                        abort_pend_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else if (m_done) begin
                        data_d    = m_rdata;
                        src_ptr_d = src_ptr_q + 32'd4;
                        if (abort_pend_d) begin
                            abort_pend_d = 1'b0;
                            state_d      = ST_IDLE;
                        end else begin
                            gap_d   = 1'b1;
                            state_d = ST_WR;
                        end
                    end
                end else if (abort_pend_d) begin
                    abort_pend_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            ST_WR: begin
                if (!gap_q) begin
                    if (m_fault) begin
                        fault_d      = 1'b1;
                        fault_addr_d = dst_ptr_q;
                        abort_pend_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else if (m_done) begin
                        dst_ptr_d = dst_ptr_q + 32'd4;
                        remain_d  = remain_q - LEN_W'(1);
                        if (abort_pend_d) begin
                            abort_pend_d = 1'b0;
                            state_d      = ST_IDLE;
                        end else if (remain_q == LEN_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            gap_d   = 1'b1;
                            state_d = ST_RD;
                        end
                    end
                end else if (abort_pend_d) begin
                    abort_pend_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and register update with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remain_q     <= '0;
            data_q       <= '0;
            fault_addr_q <= '0;
            gap_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            irq_en_q     <= IRQ_DEFAULT;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            align_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            remain_q     <= remain_d;
            data_q       <= data_d;
            fault_addr_q <= fault_addr_d;
            gap_q        <= gap_d;
            abort_pend_q <= abort_pend_d;
            irq_en_q     <= irq_en_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            align_q      <= align_d;
        end
    end

endmodule

// File: tb/tb_harvos_dma_copy_master.sv
// Bench for harvos_dma_copy_master: a memory responder acts as the bus slave and
// monitor, popping expected beats from a queue filled by the stimulus thread.
`timescale 1ns/1ps
module tb_harvos_dma_copy_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        m_req, m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_done = 1'b0;
    logic        m_fault = 1'b0;
    logic        irq;

    harvos_dma_copy_master #(.LEN_W(16), .IRQ_DEFAULT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_done(m_done),
        .m_fault(m_fault), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          beats = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    logic        fault_en = 1'b0;
    logic [31:0] fault_at = '0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return pat(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected beat stream for a copy of n_beats beats (RD/WR alternating)
    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int n_beats);
        beat_t b;
        logic [31:0] off;
        for (int i = 0; i < n_beats; i++) begin
            off = 32'(i / 2) * 32'd4;
            if (i % 2 == 0) begin
                b.we = 1'b0; b.addr = src + off; b.data = '0;
            end else begin
                b.we = 1'b1; b.addr = dst + off; b.data = rd_mem(src + off);
            end
            exp_q.push_back(b);
        end
    endtask

    // Responder + monitor: accepts beats, checks stability and the gap, scores beats
    initial begin : responder
        logic        in_beat;
        logic        just_done;
        logic        stable;
        logic [31:0] cap_addr, cap_wdata;
        logic        cap_we;
        logic [3:0]  cap_be;
        int          cnt;
        beat_t       e;
        in_beat = 1'b0; just_done = 1'b0; stable = 1'b1; cnt = 0;
        cap_addr = '0; cap_wdata = '0; cap_we = 1'b0; cap_be = '0;
        forever begin
            @(posedge clk); #1;
            m_done = 1'b0;
            m_fault = 1'b0;
            if (!rst_n) begin
                in_beat = 1'b0;
                just_done = 1'b0;
                continue;
            end
            if (just_done) begin
                check("req_gap", {31'b0, m_req}, 32'd0);
                just_done = 1'b0;
            end else if (m_req && !in_beat) begin
                in_beat = 1'b1;
                stable = 1'b1;
                cap_addr = m_addr; cap_we = m_we; cap_wdata = m_wdata; cap_be = m_be;
                cnt = $urandom_range(lat_max, lat_min);
            end
            if (in_beat) begin
                if (!m_req || m_addr !== cap_addr || m_we !== cap_we ||
                    m_wdata !== cap_wdata || m_be !== cap_be) stable = 1'b0;
                if (cnt == 0) begin
                    in_beat = 1'b0;
                    just_done = 1'b1;
                    beats++;
                    m_done = 1'b1;
                    if (fault_en && cap_we && cap_addr == fault_at) m_fault = 1'b1;
                    if (cap_we) begin
                        if (!m_fault) mem[cap_addr] = cap_wdata;
                    end else begin
                        m_rdata = rd_mem(cap_addr);
                    end
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL beat_unexpected actual_addr=%h actual_we=%b required=none", cap_addr, cap_we);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_we", {31'b0, cap_we}, {31'b0, e.we});
                        check("beat_addr", cap_addr, e.addr);
                        check("beat_be", {28'b0, cap_be}, {28'b0, {4{e.we}}});
                        if (e.we) check("beat_wdata", cap_wdata, e.data);
                        check("beat_stable", {31'b0, stable}, 32'd1);
                    end
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
        cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_en = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic expect_reg(input string name, input logic [3:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        cfg_addr = a;
        #1;
        check(name, cfg_rdata, exp);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            cfg_addr = 4'd4;
            #1;
            if (!cfg_rdata[0]) break;
            n++;
            if (n > budget) begin
                checks++;
                errors++;
                $display("FAIL wait_idle actual=busy_after_%0d_cycles required=idle", n);
                break;
            end
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin : stim
        int b0;
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        cfg_addr = 4'd4;
        #1;
        check("rst_m_req", {31'b0, m_req}, 32'd0);
        check("rst_m_we", {31'b0, m_we}, 32'd0);
        check("rst_m_be", {28'b0, m_be}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_status", cfg_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_reg("rst_ctrl", 4'd3, 32'd0);

        // 1: basic 4-word copy
        lat_min = 1; lat_max = 1;
        cfg_write(4'd0, 32'h2000_0000);
        cfg_write(4'd1, 32'h2000_0100);
        cfg_write(4'd2, 32'd4);
        push_copy(32'h2000_0000, 32'h2000_0100, 8);
        cfg_write(4'd3, 32'h1);
        wait_idle(200);
        expect_reg("t1_status", 4'd4, 32'h2);
        expect_reg("t1_remain", 4'd6, 32'd0);
        check("t1_irq_off", {31'b0, irq}, 32'd0);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 4; i++)
            check("t1_mem", rd_mem(32'h2000_0100 + 32'(i) * 4), pat(32'h2000_0000 + 32'(i) * 4));
        cfg_write(4'd3, 32'h4);
        expect_reg("t1_ctrl", 4'd3, 32'h4);
        check("t1_irq_on", {31'b0, irq}, 32'd1);
        cfg_write(4'd4, 32'h2);
        expect_reg("t1_w1c", 4'd4, 32'h0);
        check("t1_irq_clr", {31'b0, irq}, 32'd0);

        // 2: zero length, misalignment, register boundaries
        b0 = beats;
        cfg_write(4'd2, 32'd0);
        cfg_write(4'd3, 32'h5);
        expect_reg("t2_len0_status", 4'd4, 32'h2);
        check("t2_irq", {31'b0, irq}, 32'd1);
        cfg_write(4'd0, 32'h2000_0002);
        cfg_write(4'd2, 32'd3);
        cfg_write(4'd3, 32'h5);
        repeat (4) @(posedge clk);
        expect_reg("t2_align_status", 4'd4, 32'h8);
        check("t2_no_beats", 32'(beats - b0), 32'd0);
        cfg_write(4'd2, 32'hFFFF_0005);
        expect_reg("t2_len_trunc", 4'd2, 32'h5);
        expect_reg("t2_unmapped", 4'd7, 32'h0);
        cfg_write(4'd4, 32'hE);

        // 3: fault on the second write beat
        lat_min = 0; lat_max = 2;
        fault_en = 1'b1; fault_at = 32'h2000_0104;
        cfg_write(4'd0, 32'h2000_0000);
        cfg_write(4'd1, 32'h2000_0100);
        cfg_write(4'd2, 32'd4);
        push_copy(32'h2000_0000, 32'h2000_0100, 4);
        cfg_write(4'd3, 32'h5);
        wait_idle(200);
        fault_en = 1'b0;
        expect_reg("t3_status", 4'd4, 32'h4);
        expect_reg("t3_faddr", 4'd5, 32'h2000_0104);
        expect_reg("t3_remain", 4'd6, 32'd3);
        check("t3_q_empty", 32'(exp_q.size()), 32'd0);
        cfg_write(4'd4, 32'hE);

        // 4: abort during the third read
        lat_min = 3; lat_max = 3;
        b0 = beats;
        cfg_write(4'd0, 32'h3000_0000);
        cfg_write(4'd1, 32'h3000_1000);
        cfg_write(4'd2, 32'd8);
        push_copy(32'h3000_0000, 32'h3000_1000, 5);
        cfg_write(4'd3, 32'h5);
        n = 0;
        forever begin
            @(posedge clk); #2;
            if (beats - b0 == 4 && m_req && !m_we) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL t4_wait_rd3 actual=not_seen required=third_read");
                break;
            end
        end
        cfg_write(4'd3, 32'h6);
        wait_idle(200);
        expect_reg("t4_status", 4'd4, 32'h0);
        expect_reg("t4_remain", 4'd6, 32'd6);
        check("t4_q_empty", 32'(exp_q.size()), 32'd0);
        check("t4_beats", 32'(beats - b0), 32'd5);

        // 5: random latency, writes while busy ignored
        lat_min = 0; lat_max = 5;
        cfg_write(4'd0, 32'h4000_0000);
        cfg_write(4'd1, 32'h4000_2000);
        cfg_write(4'd2, 32'd16);
        push_copy(32'h4000_0000, 32'h4000_2000, 32);
        cfg_write(4'd3, 32'h5);
        repeat (5) @(posedge clk);
        #1;
        cfg_write(4'd0, 32'h5000_0000);
        cfg_write(4'd2, 32'd3);
        cfg_write(4'd3, 32'h5);
        wait_idle(2000);
        expect_reg("t5_status", 4'd4, 32'h2);
        expect_reg("t5_src_kept", 4'd0, 32'h4000_0000);
        expect_reg("t5_len_kept", 4'd2, 32'd16);
        check("t5_q_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 16; i++)
            check("t5_mem", rd_mem(32'h4000_2000 + 32'(i) * 4), pat(32'h4000_0000 + 32'(i) * 4));

        // Pointer wrap past 2^32
        lat_min = 0; lat_max = 0;
        cfg_write(4'd0, 32'hFFFF_FFFC);
        cfg_write(4'd1, 32'h4000_3000);
        cfg_write(4'd2, 32'd2);
        push_copy(32'hFFFF_FFFC, 32'h4000_3000, 4);
        cfg_write(4'd3, 32'h5);
        wait_idle(200);
        expect_reg("wrap_status", 4'd4, 32'h2);
        check("wrap_q_empty", 32'(exp_q.size()), 32'd0);

        // 6: W1C of done coinciding with the completion that sets it
        lat_min = 2; lat_max = 2;
        cfg_write(4'd0, 32'h2000_0000);
        cfg_write(4'd1, 32'h2000_0200);
        cfg_write(4'd2, 32'd1);
        push_copy(32'h2000_0000, 32'h2000_0200, 2);
        cfg_write(4'd3, 32'h5);
        n = 0;
        forever begin
            @(posedge clk); #2;
            if (m_done && m_we) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL t6_wait_wr actual=not_seen required=write_done");
                break;
            end
        end
        cfg_write(4'd4, 32'h2);
        expect_reg("t6_set_wins", 4'd4, 32'h2);
        check("t6_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a write beat
        lat_min = 3; lat_max = 3;
        cfg_write(4'd2, 32'd4);
        push_copy(32'h2000_0000, 32'h2000_0200, 8);
        cfg_write(4'd3, 32'h5);
        n = 0;
        forever begin
            @(posedge clk); #2;
            if (m_req && m_we) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL rst_wait_wr actual=not_seen required=write_beat");
                break;
            end
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_req", {31'b0, m_req}, 32'd0);
        check("mid_rst_m_we", {31'b0, m_we}, 32'd0);
        check("mid_rst_m_be", {28'b0, m_be}, 32'd0);
        check("mid_rst_m_addr", m_addr, 32'd0);
        check("mid_rst_m_wdata", m_wdata, 32'd0);
        check("mid_rst_irq", {31'b0, irq}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_reg("post_rst_status", 4'd4, 32'h0);
        expect_reg("post_rst_src", 4'd0, 32'h0);
        expect_reg("post_rst_remain", 4'd6, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
